song_reader: RTL and testbench

Sequencer that walks a song stored in the song ROM and issues one note at a time to the note player. It latches a song select, fetches 12-bit note/duration entries over a one-cycle-latency ROM port, and pulses `new_note` with stable note and duration. It waits for `note_done` before fetching the next entry. It sits directly upstream of the note player, under control of the top-level play/pause logic.

---
 rtl/song_reader.sv | 137 +++++++++++++
 tb/tb_song_reader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/song_reader.sv
// song_reader: walks one song of the note ROM and hands each note to the note player.
// Build option SONG_READER_REPEAT_EN makes the song loop forever instead of stopping in DONE.
module song_reader #(
   parameter int NOTES_PER_SONG_LOG2 = 5,
   parameter int SONG_SEL_W          = 2
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      play,
   input  logic [SONG_SEL_W-1:0]                     song,
   input  logic                                      note_done,
   output logic [SONG_SEL_W+NOTES_PER_SONG_LOG2-1:0] rom_addr,
   input  logic [11:0]                               rom_data,
   output logic [5:0]                                note,
   output logic [5:0]                                duration,
   output logic                                      new_note,
   output logic                                      song_done
);

   // state     | meaning
   // IDLE      | waiting for play; song select latched on exit
   // FETCH     | rom_addr registered, ROM read in flight
   // WAIT_ROM  | rom_data valid; issue note or detect end marker
   // WAIT_DONE | note playing; waiting for note_done
   // DONE      | song finished; hold until reset or song change
   typedef enum logic [2:0] {IDLE, FETCH, WAIT_ROM, WAIT_DONE, DONE} state_t;

   localparam int ADDR_W = SONG_SEL_W + NOTES_PER_SONG_LOG2;
   localparam logic [NOTES_PER_SONG_LOG2-1:0] IDX_ONE  = 1;
   localparam logic [NOTES_PER_SONG_LOG2-1:0] IDX_LAST = '1;
   localparam logic [NOTES_PER_SONG_LOG2-1:0] IDX_ZERO = '0;

   state_t                         state, state_n;
   logic [NOTES_PER_SONG_LOG2-1:0] idx, idx_n, idx_inc;
   logic [SONG_SEL_W-1:0]          song_q, song_q_n;
   logic [ADDR_W-1:0]              addr_q, addr_n;
   logic [5:0]                     note_q, note_n, dur_q, dur_n;
   logic                           nn_q, nn_n, sd_q, sd_n;
   logic                           end_song;

   assign idx_inc = idx + IDX_ONE;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         idx    <= '0;
         song_q <= '0;
         addr_q <= '0;
         note_q <= '0;
         dur_q  <= '0;
         nn_q   <= 1'b0;
         sd_q   <= 1'b0;
      end else begin
         state  <= state_n;
         idx    <= idx_n;
         song_q <= song_q_n;
         addr_q <= addr_n;
         note_q <= note_n;
         dur_q  <= dur_n;
         nn_q   <= nn_n;
         sd_q   <= sd_n;
      end
   end

   always_comb begin
      state_n  = state;
      idx_n    = idx;
      song_q_n = song_q;
      addr_n   = addr_q;
      note_n   = note_q;
      dur_n    = dur_q;
      nn_n     = 1'b0;
      sd_n     = 1'b0;
      end_song = 1'b0;
      if (state != IDLE && song != song_q) begin
         state_n = IDLE;
         idx_n   = '0;
      end else if (state != IDLE && !play) begin
         // frozen: a strobe still registered is kept pending for the resume cycle
         nn_n = nn_q;
         sd_n = sd_q;
      end else begin
         case (state)
            IDLE: begin
               if (play) begin
                  song_q_n = song;
                  idx_n    = '0;
                  addr_n   = {song, IDX_ZERO};
                  state_n  = FETCH;
               end
            end
            FETCH:    state_n = WAIT_ROM;
            WAIT_ROM: begin
               if (rom_data[5:0] != 6'd0) begin
                  note_n  = rom_data[11:6];
                  dur_n   = rom_data[5:0];
                  nn_n    = 1'b1;
                  state_n = WAIT_DONE;
               end else begin
                  end_song = 1'b1;
               end
            end
            WAIT_DONE: begin
               // nn_q marks the first cycle here, whose note_done belongs to the old note
               if (note_done && !nn_q) begin
                  if (idx == IDX_LAST) begin
                     end_song = 1'b1;
                  end else begin
                     idx_n   = idx_inc;
                     addr_n  = {song_q, idx_inc};
                     state_n = FETCH;
                  end
               end
            end
            DONE:    state_n = DONE;
            default: state_n = IDLE;
         endcase
         if (end_song) begin
            sd_n = 1'b1;
`ifdef SONG_READER_REPEAT_EN
            idx_n   = '0;
            addr_n  = {song_q, IDX_ZERO};
            state_n = FETCH;
`else
            state_n = DONE;
`endif
         end
      end
   end

   assign rom_addr  = addr_q;
   assign note      = note_q;
   assign duration  = dur_q;
   assign new_note  = nn_q & play;
   assign song_done = sd_q & play;

endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader: plays ROM songs against an expected-note list derived from the ROM contents.
module tb_song_reader;
   logic        clk = 1'b0;
   logic        reset, play, note_done;
   logic [1:0]  song;
   logic [6:0]  rom_addr;
   logic [11:0] rom_data;
   logic [5:0]  note, duration;
   logic        new_note, song_done;
   logic [11:0] rom_mem [128];
   int          checks = 0;
   int          errors = 0;

   song_reader dut (
      .clk(clk), .reset(reset), .play(play), .song(song), .note_done(note_done),
      .rom_addr(rom_addr), .rom_data(rom_data), .note(note), .duration(duration),
      .new_note(new_note), .song_done(song_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; play = 1'b0; note_done = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // waits (bounded) for the next strobe; lat counts negedges from the caller's drive point
   task automatic wait_strobe(input int budget, output int lat, output bit nn, output bit sd);
      lat = 0; nn = 1'b0; sd = 1'b0;
      while (lat < budget) begin
         @(negedge clk);
         lat++;
         note_done = 1'b0;
         if (new_note || song_done) begin
            nn = new_note;
            sd = song_done;
            check("excl", 32'(new_note & song_done), 0);
            return;
         end
      end
   endtask

   task automatic gap_then_done(input int g);
      for (int i = 0; i < g; i++) begin
         @(negedge clk);
         if (i == 0) check("nn_1cyc", 32'(new_note), 0);
      end
      note_done = 1'b1;
   endtask

   task automatic check_note(input string tag, input int s, input int k);
      logic [11:0] e;
      e = rom_mem[s*32 + k];
      check({tag, "_note"}, 32'(note), 32'(e[11:6]));
      check({tag, "_dur"}, 32'(duration), 32'(e[5:0]));
      check({tag, "_addr"}, 32'(rom_addr), s*32 + k);
   endtask

   task automatic run_song(input int s, input int g, input int loops);
      int n, lat, exp_lat, cnt;
      bit nn, sd;
      logic [6:0] a;
      logic [11:0] e;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         e = rom_mem[s*32 + i];
         if (e[5:0] == 6'd0) break;
         n++;
      end
      song = 2'(s); play = 1'b1; exp_lat = 3;
      for (int rep = 0; rep < loops; rep++) begin
         for (int k = 0; k < n; k++) begin
            wait_strobe(60, lat, nn, sd);
            check("nn_lat", lat, exp_lat);
            check("nn_seen", 32'(nn), 1);
            check_note("song", s, k);
            gap_then_done(g);
            exp_lat = 3;
         end
         wait_strobe(60, lat, nn, sd);
         check("sd_lat", lat, (n == 32) ? 1 : 3);
         check("sd_seen", 32'(sd), 1);
         exp_lat = 2;
      end
`ifndef SONG_READER_REPEAT_EN
      a = rom_addr; cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (new_note || song_done) cnt++;
      end
      check("done_quiet", cnt, 0);
      check("no_fetch", 32'(rom_addr), 32'(a));
`endif
   endtask

   task automatic fill_song(input int s, input int len);
      for (int i = 0; i < 32; i++) begin
         if (i < len) rom_mem[s*32 + i] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 63))};
         else if (i == len) rom_mem[s*32 + i] = {6'($urandom_range(0, 63)), 6'd0};
         else rom_mem[s*32 + i] = 12'($urandom);
      end
   endtask

   initial begin
      int lat, cnt;
      bit nn, sd;
      logic [6:0] a;
      fill_song(0, 2);
      rom_mem[0] = {6'd5, 6'd2};
      rom_mem[1] = {6'd9, 6'd1};
      fill_song(1, $urandom_range(3, 31));
      fill_song(2, 32);
      fill_song(3, $urandom_range(1, 31));
      song = 2'd0;
      do_reset();
      check("rst_nn", 32'(new_note), 0);
      check("rst_sd", 32'(song_done), 0);
      check("rst_addr", 32'(rom_addr), 0);
      check("rst_note", 32'(note), 0);

`ifdef SONG_READER_REPEAT_EN
      run_song(0, 10, 2);
`else
      run_song(0, 10, 1);
`endif
      do_reset();
      run_song(2, $urandom_range(1, 12), 1);
      do_reset();
      run_song(1, $urandom_range(1, 12), 1);

      // pause: pending strobe, then note_done dropped while paused
      do_reset();
      song = 2'd1; play = 1'b1;
      wait_strobe(60, lat, nn, sd);
      check("p_first", 32'(nn), 1);
      play = 1'b0;
      #1 check("p_forced", 32'(new_note), 0);
      repeat (5) @(negedge clk);
      play = 1'b1;
      #1 check("p_pending", 32'(new_note), 1);
      @(negedge clk);
      check("p_pend_1cyc", 32'(new_note), 0);
      play = 1'b0; a = rom_addr; cnt = 0;
      for (int i = 0; i < 20; i++) begin
         note_done = (i == 10);
         @(negedge clk);
         if (new_note || song_done) cnt++;
      end
      note_done = 1'b0;
      check("p_quiet", cnt, 0);
      check("p_addr", 32'(rom_addr), 32'(a));
      play = 1'b1; cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (new_note || song_done) cnt++;
      end
      check("p_rewait", cnt, 0);
      note_done = 1'b1;
      wait_strobe(60, lat, nn, sd);
      check("p_next_lat", lat, 3);
      check_note("p_next", 1, 1);

      // song change mid-note, then note_done in the first cycle, then reset in WAIT_ROM
      do_reset();
      song = 2'd1; play = 1'b1;
      wait_strobe(60, lat, nn, sd);
      check_note("sc_old", 1, 0);
      repeat (3) @(negedge clk);
      song = 2'd3;
      wait_strobe(60, lat, nn, sd);
      check("sc_lat", lat, 4);
      check("sc_seen", 32'(nn), 1);
      check_note("sc_new", 3, 0);
      note_done = 1'b1;
      @(negedge clk);
      note_done = 1'b0; cnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (new_note || song_done) cnt++;
      end
      check("first_nd_ignored", cnt, 0);
      note_done = 1'b1;
      @(negedge clk);
      note_done = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("r_nn", 32'(new_note), 0);
      check("r_sd", 32'(song_done), 0);
      check("r_note", 32'(note), 0);
      check("r_dur", 32'(duration), 0);
      check("r_addr", 32'(rom_addr), 0);
      cnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (new_note || song_done) cnt++;
      end
      check("r_quiet", cnt, 0);
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
